rv32_instr_encoder: RTL
=======================

# rv32_instr_encoder

Assembles RV32I instruction words from decoded fields (format, opcode, funct3, funct7, r_d, rs_1, rs_2, IMM). It is the reverse path of the existing instruction decoder, which splits a word into those fields. Encoded words are buffered in a small FIFO and streamed out with a byte address, ready to be written into instruction memory. Used to load programs from a stimulus source and to round-trip check the decoder.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 8, width of output byte address
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  field set presented
- in_ready  out  1  encoder can accept (FIFO not full)
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- opcode  in  7  instruction bits [6:0]
- funct3  in  3  instruction bits [14:12] (R/I/S/B)
- funct7  in  7  instruction bits [31:25] (R only)
- r_d, rs_1, rs_2  in  5 each  register indices
- IMM  in  21  immediate (see Operation)
- out_valid  out  1  encoded word available
- out_ready  in  1  sink accepts word
- instr_out  out  32  encoded word (FIFO head)
- addr_out  out  ADDR_W  byte address of instr_out
- level  out  clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: illegal fmt or misaligned B/J immediate seen

## Operation
- Accept on in_valid && in_ready. The word is encoded combinationally and pushed into the FIFO on that edge.
- Encodings (MSB→LSB):
  - R: funct7|rs_2|rs_1|funct3|r_d|opcode
  - I: IMM[11:0]|rs_1|funct3|r_d|opcode
  - S: IMM[11:5]|rs_2|rs_1|funct3|IMM[4:0]|opcode
  - B: IMM[12]|IMM[10:5]|rs_2|rs_1|funct3|IMM[4:1]|IMM[11]|opcode
  - U: IMM[19:0]|r_d|opcode. IMM holds the upper 20 bits, not shifted.
  - J: IMM[20]|IMM[10:1]|IMM[11]|IMM[19:12]|r_d|opcode
- Field bits not used by a format are ignored. IMM bits above the format's range are ignored; no range check is made.
- Illegal fmt (6/7), or B/J with IMM[0]=1:
  - The transfer still completes (in_ready unaffected).
  - Nothing is pushed.
  - err is set and stays set until reset.
- Output side:
  - out_valid = (level != 0).
  - instr_out is the FIFO head.
  - On out_valid && out_ready: the head pops and addr_out += 4, modulo 2^ADDR_W, wrapping to 0.
- Push and pop in the same cycle: level is unchanged; both operations take effect.
- When full, in_ready=0 even if a pop happens that cycle. There is no pass-through of a new word into a full FIFO.

## Timing
- Reset (async assert, sync-safe release) sets:
  - in_ready=1, out_valid=0, level=0, addr_out=0, err=0
  - instr_out=0 (contents don't-care, but drive 0 when empty)
  - FIFO contents discarded.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N, i.e. in cycle N+1, when the FIFO was empty.
- in_ready and out_valid are derived from registered level only. Neither depends combinationally on in_valid or out_ready.
- instr_out and addr_out are held stable while out_valid && !out_ready.
- Reset asserted mid-stream: all state clears immediately. Words in flight are lost. Address restarts at 0.
- Throughput: 1 word/cycle sustained when out_ready stays high.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release. Require in_ready=1, out_valid=0, level=0, addr_out=0, err=0.
- R/I/S (out_ready=1), expected words at addr 0, 4, 8:
  - add x3,x1,x2 (fmt0, op 0x33, f3 0, f7 0) → 0x002081B3
  - addi x5,x0,-1 (fmt1, op 0x13, IMM 0xFFF) → 0xFFF00293
  - sw x2,8(x1) (fmt2, op 0x23, f3 2, IMM 8) → 0x0020A423
- B/J/U:
  - beq x0,x0,-4 (fmt3, op 0x63, IMM 0x1FFFFC) → 0xFE000EE3
  - jal x1,8 (fmt5, op 0x6F, IMM 8) → 0x008000EF
  - lui x10,0x12345 (fmt4, op 0x37) → 0x12345537
- Backpressure: out_ready=0, offer 5 words. Require in_ready=0 after the 4th accept and level=4. Raise out_ready: require the 5 words in original order at addrs 0, 4, 8, 12, 16, and the 5th accepted on the first pop cycle +1.
- Errors: fmt=7, then fmt3 with IMM=5. Require err=1 from the first, level unchanged, and addr_out not advanced. err stays 1 until rst=0.
- Wrap/reset mid-stream:
  - With ADDR_W=8, stream 65 words. Require the 64th at addr 252 and the 65th at addr 0.
  - Assert rst with level=3. Require level=0 and out_valid=0 asynchronously.

Source files
------------

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs RV32I fields into instruction words and streams them out of a small FIFO with byte addresses
module rv32_instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               fmt,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [4:0]               r_d,
  input  logic [4:0]               rs_1,
  input  logic [4:0]               rs_2,
  input  logic [20:0]              IMM,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instr_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   word;
  logic          bad, take, push, pop;
  always_comb begin
    word = '0;
    case (fmt)
      3'd0: word = {funct7, rs_2, rs_1, funct3, r_d, opcode};
      3'd1: word = {IMM[11:0], rs_1, funct3, r_d, opcode};
      3'd2: word = {IMM[11:5], rs_2, rs_1, funct3, IMM[4:0], opcode};
      3'd3: word = {IMM[12], IMM[10:5], rs_2, rs_1, funct3, IMM[4:1], IMM[11], opcode};
      3'd4: word = {IMM[19:0], r_d, opcode};
      3'd5: word = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], r_d, opcode};
      default: word = '0;
    endcase
  end
  // illegal or misaligned requests are consumed but never stored
  assign bad       = (fmt > 3'd5) || ((fmt == 3'd3 || fmt == 3'd5) && IMM[0]);
  assign in_ready  = level != (AW+1)'(DEPTH);
  assign out_valid = level != '0;
  assign take      = in_valid && in_ready;
  assign push      = take && !bad;
  assign pop       = out_valid && out_ready;
  assign instr_out = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      addr_out <= '0;
      err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pop) addr_out <= addr_out + ADDR_W'(4);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (take && bad) err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end
endmodule
